// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-SRAM request/response bus between the memory access unit and the data SRAM.
//   master (unit):  drives data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata;
//                   receives data_addr_ok, data_data_ok, data_rdata.
//   slave (SRAM):   the mirror image.
interface mem_access_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer bridging the EX stage to a request/ack data SRAM.
//   clk, resetn (async, active-low)
//   EX side:  in_valid, mem_read, mem_write, mem_type[2:0], addr[31:0], wdata[31:0], flush
//   SRAM:     bus (mem_access_unit_if.master)
//   Pipeline: stall
//   WB side:  wb_valid, wb_memdata[31:0], wb_mem_type[2:0], wb_exception[3:0], wb_badvaddr[31:0]
//   Optional: define ADDR_ERR_EXC_EN to raise address-error exceptions on misaligned half/word accesses.
module mem_access_unit (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              flush,
    mem_access_unit_if.master bus,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_memdata,
    output logic [2:0]        wb_mem_type,
    output logic [3:0]        wb_exception,
    output logic [31:0]       wb_badvaddr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state;
    logic        flushed;
    logic        is_mem;
    logic        misalign;
    logic        accept;
    logic        done;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;
    logic [31:0] req_addr;
    assign is_mem = mem_read | mem_write;
`ifdef ADDR_ERR_EXC_EN
    assign misalign = (mem_type[1:0] == 2'd1 && addr[0]) || (mem_type[1:0] == 2'd2 && addr[1:0] != 2'd0);
    assign req_addr = addr;
`else
    assign misalign = 1'b0;
    assign req_addr = mem_type[1:0] == 2'd0 ? addr : {addr[31:2], 2'b00};
`endif
    // resetn gate keeps stall low while reset holds the FSM in IDLE
    assign accept = resetn && state == IDLE && in_valid && is_mem && !flush && !misalign;
    assign stall = accept || state != IDLE;
    assign strb = mem_type[1:0] == 2'd0 ? 4'b0001 << addr[1:0] :
                  mem_type[1:0] == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = mem_type[1:0] == 2'd0 ? {4{wdata[7:0]}} :
                       mem_type[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
    // data_ok only counts once the address has been taken (this cycle or earlier)
    assign done = (state == WAIT || (state == REQ && bus.data_addr_ok)) && bus.data_data_ok;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            flushed        <= 1'b0;
            bus.data_req   <= 1'b0;
            bus.data_wr    <= 1'b0;
            bus.data_size  <= 2'd0;
            bus.data_addr  <= 32'h0;
            bus.data_wstrb <= 4'b0;
            bus.data_wdata <= 32'h0;
            wb_valid       <= 1'b0;
            wb_memdata     <= 32'h0;
            wb_mem_type    <= 3'd0;
            wb_exception   <= 4'd0;
            wb_badvaddr    <= 32'h0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        wb_mem_type  <= mem_type;
                        wb_exception <= 4'd0;
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                        end else if (misalign) begin
                            wb_valid     <= 1'b1;
                            wb_exception <= mem_read ? 4'd4 : 4'd5;
                            wb_badvaddr  <= addr;
                        end else begin
                            state          <= REQ;
                            bus.data_req   <= 1'b1;
                            bus.data_wr    <= mem_write;
                            bus.data_size  <= mem_type[1:0];
                            bus.data_addr  <= req_addr;
                            bus.data_wstrb <= mem_write ? strb : 4'b0;
                            bus.data_wdata <= wdata_rep;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (state == REQ && bus.data_addr_ok) begin
                        bus.data_req <= 1'b0;
                        state        <= WAIT;
                    end
                    // a flush seen at any point of the transaction kills its writeback
                    if (done) begin
                        state      <= IDLE;
                        wb_valid   <= !(flushed || flush);
                        wb_memdata <= bus.data_rdata;
                        flushed    <= 1'b0;
                    end else begin
                        flushed <= flushed || flush;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
`ifdef ADDR_ERR_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_type = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_memdata;
    logic [2:0]  wb_mem_type;
    logic [3:0]  wb_exception;
    logic [31:0] wb_badvaddr;
    mem_access_unit_if bus();
    mem_access_unit dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_type(mem_type), .addr(addr), .wdata(wdata), .flush(flush), .bus(bus), .stall(stall),
        .wb_valid(wb_valid), .wb_memdata(wb_memdata), .wb_mem_type(wb_mem_type),
        .wb_exception(wb_exception), .wb_badvaddr(wb_badvaddr)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    logic        chk_en = 1'b0;
    logic        e_rst = 1'b0, e_req = 1'b0, e_stall = 1'b0, e_wbv = 1'b0;
    logic        e_wr = 1'b0, e_wchk = 1'b0, e_mchk = 1'b0, e_bchk = 1'b0;
    logic [1:0]  e_size = 2'd0;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_mem = 32'h0, e_bad = 32'h0;
    logic [3:0]  e_strb = 4'h0, e_exc = 4'h0;
    logic [2:0]  e_type = 3'd0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    function automatic logic [3:0] m_strb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        int n, off;
        logic [3:0] r;
        n = 1 << sz;
        off = (int'(a[1:0]) / n) * n;
        r = 4'h0;
        for (int k = 0; k < 4; k++) r[k] = wr && k >= off && k < off + n;
        return r;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        int n;
        logic [31:0] r;
        n = 1 << sz;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(k % n) +: 8];
        return r;
    endfunction
    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return EXC && (int'(a[1:0]) % (1 << sz)) != 0;
    endfunction
    function automatic logic [31:0] m_addr(input logic [1:0] sz, input logic [31:0] a);
        return (EXC || sz == 2'd0) ? a : {a[31:2], 2'b00};
    endfunction
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_req", 32'(bus.data_req), 32'(e_req));
            check("stall", 32'(stall), 32'(e_stall));
            check("wb_valid", 32'(wb_valid), 32'(e_wbv));
            if (e_rst) begin
                check("rst_data_wr", 32'(bus.data_wr), 32'h0);
                check("rst_data_size", 32'(bus.data_size), 32'h0);
                check("rst_data_addr", bus.data_addr, 32'h0);
                check("rst_data_wstrb", 32'(bus.data_wstrb), 32'h0);
                check("rst_data_wdata", bus.data_wdata, 32'h0);
                check("rst_wb_memdata", wb_memdata, 32'h0);
                check("rst_wb_mem_type", 32'(wb_mem_type), 32'h0);
                check("rst_wb_exception", 32'(wb_exception), 32'h0);
                check("rst_wb_badvaddr", wb_badvaddr, 32'h0);
            end
            if (e_req) begin
                check("data_wr", 32'(bus.data_wr), 32'(e_wr));
                check("data_size", 32'(bus.data_size), 32'(e_size));
                check("data_addr", bus.data_addr, e_addr);
                check("data_wstrb", 32'(bus.data_wstrb), 32'(e_strb));
                if (e_wchk) check("data_wdata", bus.data_wdata, e_wdata);
            end
            if (e_wbv) begin
                check("wb_mem_type", 32'(wb_mem_type), 32'(e_type));
                check("wb_exception", 32'(wb_exception), 32'(e_exc));
                if (e_mchk) check("wb_memdata", wb_memdata, e_mem);
                if (e_bchk) check("wb_badvaddr", wb_badvaddr, e_bad);
            end
        end
    end
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic noise();
        bus.data_addr_ok = 1'($urandom);
        bus.data_data_ok = 1'($urandom);
        bus.data_rdata = $urandom;
    endtask
    task automatic quiet();
        e_rst = 1'b0; e_req = 1'b0; e_stall = 1'b0; e_wbv = 1'b0;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; flush = 1'b0;
            quiet(); noise(); cycle();
        end
    endtask
    task automatic do_nonmem(input logic [2:0] ty);
        in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_type = ty; flush = 1'b0;
        quiet(); noise(); cycle();
        in_valid = 1'b0; mem_type = 3'($urandom);
        e_wbv = 1'b1; e_type = ty; e_exc = 4'd0; e_mchk = 1'b0; e_bchk = 1'b0;
        noise(); cycle();
        quiet();
    endtask
    // One load/store: la cycles before addr_ok, ld further cycles to data_ok (0 = same cycle),
    // flush pulsed on busy cycle fcyc (-1 none) or on the issue cycle when fidle.
    task automatic do_mem(input logic rd, input logic [2:0] ty, input logic [31:0] a, input logic [31:0] w,
                          input int la, input int ld, input int fcyc, input logic fidle, input logic [31:0] rdv);
        logic mis, fl;
        mis = m_mis(ty[1:0], a);
        in_valid = 1'b1; mem_read = rd; mem_write = !rd; mem_type = ty; addr = a; wdata = w; flush = fidle;
        quiet(); e_stall = !fidle && !mis; noise(); cycle();
        in_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = $urandom; wdata = $urandom; mem_type = 3'($urandom);
        if (fidle) begin
            quiet(); noise(); cycle();
            return;
        end
        if (mis) begin
            quiet(); e_wbv = 1'b1; e_type = ty; e_exc = rd ? 4'd4 : 4'd5; e_mchk = 1'b0;
            e_bchk = 1'b1; e_bad = a;
            noise(); cycle();
            quiet();
            return;
        end
        e_wr = !rd; e_size = ty[1:0]; e_addr = m_addr(ty[1:0], a); e_strb = m_strb(!rd, ty[1:0], a);
        e_wchk = !rd; e_wdata = m_wdata(ty[1:0], w);
        fl = 1'b0;
        for (int i = 0; i <= la + ld; i++) begin
            e_req = i <= la; e_stall = 1'b1; e_wbv = 1'b0;
            bus.data_addr_ok = i == la;
            bus.data_data_ok = i == la + ld;
            bus.data_rdata = (i == la + ld) ? rdv : $urandom;
            flush = i == fcyc;
            if (i == fcyc) fl = 1'b1;
            cycle();
        end
        flush = 1'b0;
        e_req = 1'b0; e_stall = 1'b0; e_wbv = !fl; e_type = ty; e_exc = 4'd0;
        e_mchk = rd; e_mem = rdv; e_bchk = 1'b0;
        noise(); cycle();
        quiet();
    endtask
    task automatic reset_in_req();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_type = 3'd2; addr = 32'h1000_0008;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        quiet(); e_stall = 1'b1; cycle();
        in_valid = 1'b0;
        e_req = 1'b1; e_wr = 1'b0; e_size = 2'd2; e_addr = 32'h1000_0008; e_strb = 4'h0; e_wchk = 1'b0;
        cycle();
        resetn = 1'b0; in_valid = 1'b1;
        quiet(); e_rst = 1'b1; cycle();
        cycle();
        resetn = 1'b1;
    endtask
    initial begin
        check("pin_strb_sb", 32'(m_strb(1'b1, 2'd0, 32'h3)), 32'h8);
        check("pin_wdata_sb", m_wdata(2'd0, 32'h12), 32'h1212_1212);
        check("pin_strb_sh", 32'(m_strb(1'b1, 2'd1, 32'h2)), 32'hC);
        check("pin_strb_lw", 32'(m_strb(1'b0, 2'd2, 32'h4)), 32'h0);
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        in_valid = 1'b1; mem_read = 1'b1;
        e_rst = 1'b1; chk_en = 1'b1;
        cycle(); cycle();
        resetn = 1'b1;
        do_mem(1'b1, 3'b010, 32'h1000_0004, 32'h0, 2, 3, -1, 1'b0, 32'hDEAD_BEEF);
        do_mem(1'b0, 3'b000, 32'h2000_0003, 32'h12, 0, 1, -1, 1'b0, 32'h0);
        do_mem(1'b0, 3'b001, 32'h2000_0002, 32'h0000_ABCD, 1, 1, -1, 1'b0, 32'h0);
        do_mem(1'b1, 3'b110, 32'h3000_0010, 32'h0, 0, 0, -1, 1'b0, 32'h5555_AAAA);
        do_mem(1'b1, 3'b010, 32'h3000_0020, 32'h0, 1, 3, 3, 1'b0, 32'h1234_5678);
        do_nonmem(3'b101);
        do_mem(1'b0, 3'b010, 32'h3000_0030, 32'hFFFF_0000, 0, 1, -1, 1'b1, 32'h0);
        do_mem(1'b1, 3'b010, 32'h0000_0002, 32'h0, 0, 1, -1, 1'b0, 32'hCAFE_F00D);
        do_mem(1'b0, 3'b001, 32'h0000_0101, 32'h0000_7777, 1, 0, -1, 1'b0, 32'h0);
        idle(2);
        reset_in_req();
        do_mem(1'b1, 3'b001, 32'h4000_0006, 32'h0, 1, 2, -1, 1'b0, 32'h0BAD_CAFE);
        for (int t = 0; t < 300; t++) begin
            logic rd;
            logic [2:0] ty;
            int la, ld, fc;
            rd = 1'($urandom);
            ty = {1'($urandom), 2'($urandom_range(0, 2))};
            la = $urandom_range(0, 3);
            ld = $urandom_range(0, 3);
            fc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, la + ld) : -1;
            if ($urandom_range(0, 5) == 0) do_nonmem(3'($urandom));
            else do_mem(rd, ty, $urandom, $urandom, la, ld, fc, $urandom_range(0, 7) == 0, $urandom);
            idle($urandom_range(0, 2));
        end
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
